fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 22: word-address width of the PC and all targets.
REQ-002 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries (power of 2).
REQ-003 SHALL use one clock, i_clk (input, 1), rising-edge.
REQ-004 SHALL use reset i_reset (input, 1), synchronous, active-high.
REQ-005 i_cache_hit  input  1  bundle at o_pc valid this cycle.
REQ-006 i_stall  input  1  decode backpressure; bundle not consumed.
REQ-007 i_isbranch, i_j_inst, i_jal_inst, i_jr_inst  input  1 each  control type of first control instruction in bundle (from pre-aligner).
REQ-008 i_branch_address  input  ADDRESS_WIDTH  word address of that control instruction.
REQ-009 i_branch_target  input  ADDRESS_WIDTH  its decoded target (branch/j/jal).
REQ-010 i_delay_slot  input  1  control instruction occupies bundle slot 3.
REQ-011 i_bp_taken  input  1  predictor taken decision for i_isbranch.
REQ-012 i_redirect  input  1  execute-stage mispredict/jr resolve; i_redirect_pc  input  ADDRESS_WIDTH  correct PC.
REQ-013 o_pc  output  ADDRESS_WIDTH  fetch address presented to I-cache/pre-aligner.
REQ-014 o_fetch_valid  output  1  bundle handed to decode this cycle.
REQ-015 o_count  output  3  valid instructions in handed bundle (0-4).
REQ-016 o_ras_empty  output  1  return stack holds no entries.

Function
REQ-017 Advance ("fire") SHALL occur only when i_cache_hit && !i_stall && state != JR_WAIT; otherwise o_pc, state, RAS hold and o_fetch_valid=0.
REQ-018 States: RUN, DELAY, JR_WAIT; registered, single-cycle transitions.
REQ-019 "Taken" = (i_isbranch && i_bp_taken) || i_j_inst || i_jal_inst || i_jr_inst.
REQ-020 RUN, fire, not taken: o_count = 4 - o_pc[1:0]; next o_pc = {o_pc[AW-1:2]+1, 2'b00} (wraps at max address).
REQ-021 RUN, fire, taken, !i_delay_slot: o_count = i_branch_address - o_pc + 2 (includes delay slot); next o_pc = target.
REQ-022 RUN, fire, taken, i_delay_slot: o_count = 4 - o_pc[1:0]; latch target in pending register; next o_pc = aligned next bundle; go DELAY.
REQ-023 DELAY, fire: o_count = 1; next o_pc = pending target; go RUN; control info of this bundle ignored.
REQ-024 Target SHALL be i_branch_target for branch/j/jal, RAS top for jr.
REQ-025 jal taken SHALL push i_branch_address+2; jr taken SHALL pop.
REQ-026 Push when full SHALL overwrite oldest entry (circular pointer); depth count saturates at RAS_DEPTH.
REQ-027 jr with o_ras_empty=1 SHALL hand bundle up to delay slot (REQ-021/022 counts) then enter JR_WAIT, o_fetch_valid=0 until i_redirect.
REQ-028 i_redirect SHALL take priority over all else in any state: next o_pc = i_redirect_pc, state RUN, pending target discarded, o_fetch_valid=0 that cycle; RAS unchanged.
REQ-029 o_fetch_valid = fire and !i_redirect; o_count = 0 when o_fetch_valid=0.

Reset
REQ-030 On i_reset: o_pc=0, state RUN, pending target 0, RAS pointer and count 0, o_ras_empty=1, o_fetch_valid=0, o_count=0.
REQ-031 Reset SHALL override i_redirect and fire in the same cycle.

Configuration
REQ-032 Macro FETCH_SEQ_RAS_EN: defined -> RAS built per REQ-025/026/027.
REQ-033 Undefined -> no RAS storage; every taken jr behaves as RAS-empty (REQ-027); o_ras_empty tied 1; jal does not push.

Verification
REQ-034 Reset, i_cache_hit=1, no control: o_pc 0 -> 4 -> 8, o_count=4 each cycle.
REQ-035 o_pc=5, branch at 6, bp_taken, target 0x100: o_count=3, next o_pc=0x100.
REQ-036 o_pc=8, j at 11 (delay_slot), target 0x40: o_count=4, then o_pc=12 o_count=1, then o_pc=0x40.
REQ-037 jal at 0x20 target 0x80, later jr (RAS_EN): next o_pc after jr = 0x22; with RAS_EN undefined: JR_WAIT, o_fetch_valid=0 until i_redirect_pc=0x22.
REQ-038 Five jal pushes (depth 4) then five jr pops: first four return newest-first, fifth enters JR_WAIT.
REQ-039 i_redirect=1 pc 0x300 while in DELAY with i_stall=1: next o_pc=0x300, state RUN, pending discarded.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps the fetch PC through 4-word bundles, applies taken control flow with delay slots.
// Define FETCH_SEQ_RAS_EN to build the return-address stack; otherwise every taken jr waits for a redirect.
module fetch_sequencer #(
   parameter int unsigned ADDRESS_WIDTH = 22,
   parameter int unsigned RAS_DEPTH     = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_cache_hit,
   input  logic                     i_stall,
   input  logic                     i_isbranch,
   input  logic                     i_j_inst,
   input  logic                     i_jal_inst,
   input  logic                     i_jr_inst,
   input  logic [ADDRESS_WIDTH-1:0] i_branch_address,
   input  logic [ADDRESS_WIDTH-1:0] i_branch_target,
   input  logic                     i_delay_slot,
   input  logic                     i_bp_taken,
   input  logic                     i_redirect,
   input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
   output logic [ADDRESS_WIDTH-1:0] o_pc,
   output logic                     o_fetch_valid,
   output logic [2:0]               o_count,
   output logic                     o_ras_empty
);

   localparam int unsigned AW = ADDRESS_WIDTH;

   typedef enum logic [1:0] {
      S_RUN,
      S_DELAY,
      S_JR_WAIT
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pend_q, pend_d;
   logic          jr_wait_q, jr_wait_d;

   logic          fire;
   logic          taken;
   logic          jr_blocked;
   logic [AW-1:0] aligned_next;
   logic [AW-1:0] target;
   logic [AW-1:0] ras_top;
   logic          ras_empty;
   logic [2:0]    head_count;
   logic [2:0]    span_count;
   logic          fetch_valid;
   logic [2:0]    count;

   assign fire         = i_cache_hit && !i_stall && (state_q != S_JR_WAIT) && !i_reset;
   assign taken        = (i_isbranch && i_bp_taken) || i_j_inst || i_jal_inst || i_jr_inst;
   assign jr_blocked   = i_jr_inst && ras_empty;
   assign target       = i_jr_inst ? ras_top : i_branch_target;
   assign aligned_next = {pc_q[AW-1:2] + (AW-2)'(1), 2'b00};
   assign head_count   = 3'd4 - {1'b0, pc_q[1:0]};
   // The control instruction lies inside the current bundle, so the low three bits carry the exact distance.
   assign span_count   = i_branch_address[2:0] - pc_q[2:0] + 3'd2;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      jr_wait_d   = jr_wait_q;
      fetch_valid = 1'b0;
      count       = 3'd0;
      if (i_redirect) begin
         state_d   = S_RUN;
         pc_d      = i_redirect_pc;
         pend_d    = '0;
         jr_wait_d = 1'b0;
      end else if (fire) begin
         fetch_valid = 1'b1;
         case (state_q)
            S_RUN: begin
               if (!taken) begin
                  count = head_count;
                  pc_d  = aligned_next;
               end else if (i_delay_slot) begin
                  count     = head_count;
                  pc_d      = aligned_next;
                  pend_d    = target;
                  jr_wait_d = jr_blocked;
                  state_d   = S_DELAY;
               end else begin
                  count = span_count;
                  if (jr_blocked) state_d = S_JR_WAIT;
                  else            pc_d    = target;
               end
            end
            S_DELAY: begin
               count     = 3'd1;
               jr_wait_d = 1'b0;
               if (jr_wait_q) begin
                  state_d = S_JR_WAIT;
               end else begin
                  pc_d    = pend_q;
                  state_d = S_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= S_RUN;
         pc_q      <= '0;
         pend_q    <= '0;
         jr_wait_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         jr_wait_q <= jr_wait_d;
      end
   end

`ifdef FETCH_SEQ_RAS_EN
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [AW-1:0]    ras_mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] ras_ptr_q;
   logic [CNT_W-1:0] ras_cnt_q;
   logic             run_adv;
   logic             ras_push;
   logic             ras_pop;

   assign run_adv   = fire && !i_redirect && (state_q == S_RUN);
   assign ras_push  = run_adv && i_jal_inst;
   assign ras_pop   = run_adv && i_jr_inst && !i_jal_inst && !ras_empty;
   assign ras_empty = (ras_cnt_q == '0);
   assign ras_top   = ras_mem_q[ras_ptr_q - PTR_W'(1)];

   // Pointer wraps, so a push into a full stack silently replaces the oldest entry.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else if (ras_push) begin
         ras_ptr_q <= ras_ptr_q + PTR_W'(1);
         if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
      end else if (ras_pop) begin
         ras_ptr_q <= ras_ptr_q - PTR_W'(1);
         ras_cnt_q <= ras_cnt_q - CNT_W'(1);
      end
   end

   // NOTE: stack storage is not reset; the count guarantees no entry is read before it is written.
   always_ff @(posedge i_clk) begin
      if (ras_push) ras_mem_q[ras_ptr_q] <= i_branch_address + AW'(2);
   end
`else
   assign ras_empty = 1'b1;
   assign ras_top   = '0;
`endif

   assign o_pc          = pc_q;
   assign o_fetch_valid = fetch_valid;
   assign o_count       = count;
   assign o_ras_empty   = ras_empty;

endmodule
